// File: rtl/prdec_pkg.sv
// prdec_pkg: shared state encoding, default sizes and index
// range check for the grant decoder.
package prdec_pkg;

    localparam int PRDEC_N_OUT    = 4;
    localparam int PRDEC_IDX_W    = 2;
    localparam int PRDEC_HOLD_MAX = 15;
    localparam int PRDEC_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        EXPIRE = 2'd2
    } prdec_state_e;

    // True when an encoded index names an existing grant line.
    function automatic logic idx_in_range(
        input logic [31:0] idx,
        input logic [31:0] n_out
    );
        return idx < n_out;
    endfunction

endpackage

// File: rtl/prdec_onehot.sv
// prdec_onehot: binary index to one-hot decoder.
// Out-of-range indices decode to all-zero and drop in_range.
module prdec_onehot
    import prdec_pkg::*;
#(
    parameter int N_OUT = PRDEC_N_OUT,
    parameter int IDX_W = PRDEC_IDX_W
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N_OUT-1:0] onehot,
    output logic             in_range
);

    // Decode; the range gate keeps unused codes from
    // producing a stray grant.
    always_comb begin
        in_range = idx_in_range(32'(idx), 32'(N_OUT));
        onehot   = '0;
        for (int i = 0; i < N_OUT; i++) begin
            onehot[i] = in_range && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/prdec_grant.sv
// prdec_grant: turns a winning encoded index into a held,
// registered one-hot grant released by ack or hold timeout.
module prdec_grant
    import prdec_pkg::*;
#(
    parameter int N_OUT    = PRDEC_N_OUT,
    parameter int IDX_W    = PRDEC_IDX_W,
    parameter int HOLD_MAX = PRDEC_HOLD_MAX,
    parameter int CNT_W    = PRDEC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             in_ready,
    input  logic             ack,
    output logic [N_OUT-1:0] gnt,
    output logic             gnt_valid,
    output logic             timeout,
    output logic             err
);

    // Count value seen in the last permitted grant cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    prdec_state_e     state_q, state_d;
    logic [N_OUT-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_OUT-1:0] dec_onehot;
    logic             dec_in_range;

    prdec_onehot #(
        .N_OUT (N_OUT),
        .IDX_W (IDX_W)
    ) u_onehot (
        .idx      (in_idx),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // Next-state logic: accept in IDLE, hold in GRANT until
    // ack (which beats expiry) or the hold count runs out.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (dec_in_range) begin
                        state_d = GRANT;
                        gnt_d   = dec_onehot;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = EXPIRE;
                    gnt_d     = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXPIRE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    // State and registered outputs; reset drops any live
    // grant without raising timeout or err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prdec_grant.sv
// tb_prdec_grant: vector table plus hand sequences against a
// 4-line and a 3-line instance, checked through a queue.
module tb_prdec_grant;

    typedef struct packed {
        logic [3:0] gnt;
        logic       gv;
        logic       rdy;
        logic       to;
        logic       er;
    } out_t;

    typedef struct {
        out_t e4;
        out_t e3;
    } sb_t;

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic       ack;
        logic [3:0] g;
        logic       rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_idx = 2'd0;
    logic       ack = 1'b0;
    logic       in_ready;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;
    logic       err;

    logic       in_valid3 = 1'b0;
    logic [1:0] in_idx3 = 2'd0;
    logic       ack3 = 1'b0;
    logic       in_ready3;
    logic [2:0] gnt3;
    logic       gnt_valid3;
    logic       timeout3;
    logic       err3;

    int checks = 0;
    int failures = 0;
    sb_t sbq[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    prdec_grant #(
        .N_OUT(4), .IDX_W(2), .HOLD_MAX(15), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_idx(in_idx), .in_ready(in_ready), .ack(ack),
        .gnt(gnt), .gnt_valid(gnt_valid),
        .timeout(timeout), .err(err)
    );

    prdec_grant #(
        .N_OUT(3), .IDX_W(2), .HOLD_MAX(15), .CNT_W(4)
    ) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3),
        .in_idx(in_idx3), .in_ready(in_ready3), .ack(ack3),
        .gnt(gnt3), .gnt_valid(gnt_valid3),
        .timeout(timeout3), .err(err3)
    );

    a_idx_known: assert property (@(posedge clk) disable iff (rst)
        in_valid |-> !$isunknown(in_idx))
        else $error("FAIL idx_known in_idx=%b", in_idx);

    a_idx3_known: assert property (@(posedge clk) disable iff (rst)
        in_valid3 |-> !$isunknown(in_idx3))
        else $error("FAIL idx3_known in_idx3=%b", in_idx3);

    function automatic out_t o(input logic [3:0] g, input logic rdy,
                               input logic to, input logic er);
        out_t r;
        r.gnt = g;
        r.gv  = |g;
        r.rdy = rdy;
        r.to  = to;
        r.er  = er;
        return r;
    endfunction

    task automatic check(input string nm);
        sb_t  e;
        out_t a4;
        out_t a3;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", nm);
            return;
        end
        e  = sbq.pop_front();
        a4 = {gnt, gnt_valid, in_ready, timeout, err};
        a3 = {1'b0, gnt3, gnt_valid3, in_ready3, timeout3, err3};
        if (a4 !== e.e4) begin
            failures++;
            $display("FAIL %s dut4 got=%b expected=%b", nm, a4, e.e4);
        end
        checks++;
        if (a3 !== e.e3) begin
            failures++;
            $display("FAIL %s dut3 got=%b expected=%b", nm, a3, e.e3);
        end
        checks++;
        if ($countones(gnt) > 1 || $countones(gnt3) > 1) begin
            failures++;
            $display("FAIL %s multihot got=%b/%b expected<=1 bit",
                     nm, gnt, gnt3);
        end
    endtask

    task automatic step2(input string nm, input logic r,
                         input logic v, input logic [1:0] ix,
                         input logic a, input out_t e4,
                         input logic v3, input logic [1:0] ix3,
                         input logic a3, input out_t e3);
        sb_t s;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_idx    = ix;
        ack       = a;
        in_valid3 = v3;
        in_idx3   = ix3;
        ack3      = a3;
        s.e4 = e4;
        s.e3 = e3;
        sbq.push_back(s);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    task automatic step(input string nm, input logic r,
                        input logic v, input logic [1:0] ix,
                        input logic a, input out_t e4);
        step2(nm, r, v, ix, a, e4, 1'b0, 2'd0, 1'b0,
              o(4'b0000, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 4'b0100, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 4'b0100, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 4'b0100, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 4'b0001, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b1};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 4'b0010, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b1};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 4'b0100, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b1};
        tbl[10] = '{1'b1, 2'd3, 1'b0, 4'b1000, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b1};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 4'b0010, 1'b0};
        tbl[13] = '{1'b1, 2'd3, 1'b0, 4'b0010, 1'b0};
        tbl[14] = '{1'b1, 2'd0, 1'b1, 4'b0000, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b1};

        step("reset0", 1'b1, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));
        step("reset1", 1'b1, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));
        step("idle", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), 1'b0, tbl[i].v, tbl[i].idx,
                 tbl[i].ack, o(tbl[i].g, tbl[i].rdy, 1'b0, 1'b0));
        end

        // Full hold with no ack: 15 visible cycles, then EXPIRE.
        step("to_acc", 1'b0, 1'b1, 2'd3, 1'b0, o(4'b1000, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i < 15; i++) begin
            step($sformatf("to_hold%0d", i), 1'b0, 1'b0, 2'd0, 1'b0,
                 o(4'b1000, 1'b0, 1'b0, 1'b0));
        end
        step("to_expire", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b0, 1'b1, 1'b0));
        step("to_exit", 1'b0, 1'b1, 2'd0, 1'b1, o(4'b0000, 1'b1, 1'b0, 1'b0));
        step("to_idle", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));

        // Ack lands in the 15th grant cycle and beats expiry.
        step("ak_acc", 1'b0, 1'b1, 2'd1, 1'b0, o(4'b0010, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i < 15; i++) begin
            step($sformatf("ak_hold%0d", i), 1'b0, 1'b0, 2'd0, 1'b0,
                 o(4'b0010, 1'b0, 1'b0, 1'b0));
        end
        step("ak_last", 1'b0, 1'b0, 2'd0, 1'b1, o(4'b0000, 1'b1, 1'b0, 1'b0));
        step("ak_idle", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));

        // Reset while a grant is live.
        step("rg_acc", 1'b0, 1'b1, 2'd1, 1'b0, o(4'b0010, 1'b0, 1'b0, 1'b0));
        step("rg_hold", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0010, 1'b0, 1'b0, 1'b0));
        step("rg_rst", 1'b1, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));
        step("rg_after", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));
        step("rg_regrant", 1'b0, 1'b1, 2'd0, 1'b0, o(4'b0001, 1'b0, 1'b0, 1'b0));
        step("rg_ack", 1'b0, 1'b0, 2'd0, 1'b1, o(4'b0000, 1'b1, 1'b0, 1'b0));

        // Three-line instance: unused code 3 is rejected.
        step2("n3_err", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0),
              1'b1, 2'd3, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b1));
        step2("n3_errclr", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0),
              1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0));
        step2("n3_acc", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0),
              1'b1, 2'd2, 1'b0, o(4'b0100, 1'b0, 1'b0, 1'b0));
        step2("n3_ign", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0),
              1'b1, 2'd3, 1'b0, o(4'b0100, 1'b0, 1'b0, 1'b0));
        step2("n3_ack", 1'b0, 1'b0, 2'd0, 1'b0, o(4'b0000, 1'b1, 1'b0, 1'b0),
              1'b0, 2'd0, 1'b1, o(4'b0000, 1'b1, 1'b0, 1'b0));

        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prdec_grant.md
Name: prdec_grant

Overview:
Sequential decoder-side companion to the team's 4-to-2 priority encoder. It accepts an encoded index plus a valid strobe and drives a registered one-hot grant vector. The grant is held until the consumer acknowledges it or a hold timer expires. It sits downstream of the priority encoder in the arbitration path and turns the winning index back into a per-requester grant line.

Parameters:
N_OUT, 4, number of one-hot grant lines
IDX_W, 2, width of encoded index; must satisfy 2**IDX_W >= N_OUT
HOLD_MAX, 15, GRANT-state cycles without ack before timeout (1..2**CNT_W-1)
CNT_W, 4, width of hold counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  encoded index present this cycle
in_idx  input  IDX_W  encoded winner index (from priority encoder output a)
in_ready  output  1  block can accept an index; high only in IDLE
ack  input  1  consumer done with current grant
gnt  output  N_OUT  registered one-hot grant
gnt_valid  output  1  high while gnt is non-zero
timeout  output  1  one-cycle pulse when hold timer expires
err  output  1  one-cycle pulse when an out-of-range index is rejected

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, gnt=0, gnt_valid=0, timeout=0, err=0, counter=0; in_ready=1 from the first cycle after reset.
- Reset mid-grant: gnt clears at that same edge; no timeout or err pulse.
- All outputs are registered except in_ready, which equals (state==IDLE).
- FSM states: IDLE, GRANT, EXPIRE.
- IDLE, in_valid=1, in_idx<N_OUT: latch in_idx, go to GRANT; gnt = 1<<in_idx visible after the same edge (latency 1 cycle); counter=0.
- IDLE, in_valid=1, in_idx>=N_OUT (only possible when N_OUT<2**IDX_W): stay in IDLE, gnt stays 0, err=1 for one cycle.
- IDLE, in_valid=0: hold. ack is ignored in IDLE.
- GRANT: gnt and gnt_valid are held stable; in_valid/in_idx are ignored (in_ready=0); counter increments each cycle.
- GRANT, ack=1: go to IDLE; gnt=0 after that edge.
- GRANT, ack=0 with counter==HOLD_MAX-1: go to EXPIRE; gnt=0 and timeout=1 after that edge. A grant is therefore visible for exactly HOLD_MAX cycles.
- Simultaneous ack and expiry in the same cycle: ack wins; no timeout pulse.
- EXPIRE: lasts one cycle (timeout=1, gnt=0), then IDLE unconditionally. ack is ignored.
- Minimum spacing between two grants is 2 cycles: the grant cycle(s), then one IDLE accept cycle.
- gnt is always 0 or exactly one bit set; never multi-hot.
- Width rule: counter compares at CNT_W bits and never wraps, because HOLD_MAX<=2**CNT_W-1.
- X or Z on in_idx while in_valid=1 is a bench error. The DUT makes no guarantee for it; verification must flag it with an assertion.

Decomposition:
- Shared package prdec_pkg: state enum (IDLE, GRANT, EXPIRE), default N_OUT/IDX_W constants, and a function that range-checks an index.
- One natural combinational sub-module, prdec_onehot (IDX_W-to-N_OUT binary-to-one-hot decoder with an in_range output). It is instantiated once, ahead of the gnt register.

Test Plan:
- Reset, then in_valid=1, in_idx=2'b10 for 1 cycle -> gnt=4'b0100, gnt_valid=1 on the next cycle; ack=1 three cycles later -> gnt=4'b0000 after that edge.
- Sweep in_idx 0..3, each acked after 1 cycle -> gnt sequence 0001, 0010, 0100, 1000 with one IDLE cycle between each; never multi-hot.
- in_idx=2'b11, no ack -> gnt=4'b1000 for exactly 15 cycles, then timeout=1 for 1 cycle, then in_ready=1.
- ack asserted in the 15th grant cycle -> gnt clears, timeout stays 0.
- Grant active for idx 1, rst=1 for one edge -> gnt=0, timeout=0, err=0; in_ready=1 afterwards. With N_OUT=3, in_idx=2'b11 -> err pulse, gnt stays 0.
- During GRANT, in_valid=1 with a new idx -> ignored, gnt unchanged; ack pulses in IDLE and EXPIRE -> no effect.
